// File: rtl/instr_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : instr_line_buffer
// Description : Single 16-byte line instruction fetch buffer between an
//               OBI-style 32-bit core port and a 128-bit RAM read port.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_line_buffer #(
    parameter int ADDR_WIDTH = 22,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  core_req_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    output logic                  core_gnt_o,
    output logic                  core_rvalid_o,
    output logic [31:0]           core_rdata_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [127:0]          mem_rdata_i,
    output logic [CNT_WIDTH-1:0]  hit_cnt_o,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

    localparam int c_TAG_W = ADDR_WIDTH - 4;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_GNT    = 2'd1,
        S_WAIT_RVALID = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_line_valid;
    logic [c_TAG_W-1:0]   r_tag;
    logic [c_TAG_W-1:0]   r_mem_tag;
    logic [127:0]         r_line;
    logic                 r_drop;
    logic                 r_rvalid;
    logic [31:0]          r_rdata;
    logic [CNT_WIDTH-1:0] r_hit_cnt;
    logic [CNT_WIDTH-1:0] r_miss_cnt;

    logic [c_TAG_W-1:0]   w_tag;
    logic                 w_hit;
    logic                 w_gnt;
    logic                 w_miss;
    logic                 w_drop;
    logic                 w_install;
    logic [31:0]          w_word;
    logic                 w_unused_addr_lsb;

    assign w_tag             = core_addr_i[ADDR_WIDTH-1:4];
    assign w_hit             = r_line_valid && (r_tag == w_tag) && !flush_i;
    assign w_gnt             = (r_state == S_IDLE) && core_req_i && w_hit;
    assign w_miss            = (r_state == S_IDLE) && core_req_i && !w_hit;
    // A flush coinciding with the refill response must also discard the line.
    assign w_drop            = r_drop || flush_i;
    assign w_install         = (r_state == S_WAIT_RVALID) && mem_rvalid_i && !w_drop;
    assign w_word            = r_line[{core_addr_i[3:2], 5'd0} +: 32];
    assign w_unused_addr_lsb = ^core_addr_i[1:0];

    assign core_gnt_o    = w_gnt;
    assign core_rvalid_o = r_rvalid;
    assign core_rdata_o  = r_rdata;
    assign mem_req_o     = w_miss || (r_state == S_WAIT_GNT);
    assign mem_addr_o    = w_miss ? {w_tag, 4'b0000} : {r_mem_tag, 4'b0000};
    assign hit_cnt_o     = r_hit_cnt;
    assign miss_cnt_o    = r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_line_valid <= 1'b0;
            r_tag        <= '0;
            r_mem_tag    <= '0;
            r_line       <= '0;
            r_drop       <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_gnt) begin
                r_rdata <= w_word;
                if (r_hit_cnt != '1) begin
                    r_hit_cnt <= r_hit_cnt + 1'b1;
                end
            end

            if (flush_i) begin
                r_line_valid <= 1'b0;
            end else if (w_install) begin
                r_line_valid <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_mem_tag <= w_tag;
                        if (r_miss_cnt != '1) begin
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                        end
                        r_state <= mem_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
                    end
                end
                S_WAIT_GNT: begin
                    if (flush_i) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        r_state <= S_WAIT_RVALID;
                    end
                end
                S_WAIT_RVALID: begin
                    if (mem_rvalid_i) begin
                        if (w_install) begin
                            r_line <= mem_rdata_i;
                            r_tag  <= r_mem_tag;
                        end
                        r_drop  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (flush_i) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_line_buffer
// Description : Scoreboard bench for instr_line_buffer (4-bit perf counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_line_buffer;

    localparam int AW = 22;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic          core_req_i;
    logic [AW-1:0] core_addr_i;
    logic          core_gnt_o;
    logic          core_rvalid_o;
    logic [31:0]   core_rdata_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [127:0]  mem_rdata_i;
    logic [CW-1:0] hit_cnt_o;
    logic [CW-1:0] miss_cnt_o;

    instr_line_buffer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .core_req_i   (core_req_i),
        .core_addr_i  (core_addr_i),
        .core_gnt_o   (core_gnt_o),
        .core_rvalid_o(core_rvalid_o),
        .core_rdata_o (core_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    logic [CW-1:0] exp_hit;
    logic [CW-1:0] exp_miss;
    logic [31:0]   exp_q[$];
    logic [31:0]   mon_exp;

    int            f_ncyc;
    int            f_nreq;
    bit            f_stable;
    logic [AW-1:0] f_maddr;

    always @(posedge clk) cyc++;

    // Backing-memory contents: every word of every line is distinct.
    function automatic logic [31:0] model_word(input logic [AW-1:0] a, input logic [1:0] k);
        return {8'hA0 + {6'd0, k}, 6'd0, a[AW-1:4]};
    endfunction

    function automatic logic [127:0] line_data(input logic [AW-1:0] a);
        return {model_word(a, 2'd3), model_word(a, 2'd2), model_word(a, 2'd1), model_word(a, 2'd0)};
    endfunction

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Scoreboard: push the expected word at each grant, pop it at rvalid.
    always @(negedge clk) begin
        if (core_rvalid_o) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected: rdata=%h with no grant outstanding", core_rdata_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (core_rdata_o !== mon_exp) begin
                    n_fail++;
                    $display("FAIL rdata: got %h expected %h", core_rdata_o, mon_exp);
                end
            end
        end
        if (core_gnt_o) exp_q.push_back(model_word(core_addr_i, core_addr_i[3:2]));
    end

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one core fetch until granted while acting as the RAM.
    task automatic fetch(input logic [AW-1:0] addr, input int gdly, input int rdly, input bit flush_rv);
        int phase;
        int cnt;
        bit got;
        bit flushed;
        bit poison;
        phase = 0; cnt = 0; got = 0; flushed = 0; poison = 0;
        f_ncyc = 0; f_nreq = 0; f_stable = 1; f_maddr = '0;
        core_req_i  = 1'b1;
        core_addr_i = addr;
        while (!got && f_ncyc < 60) begin
            #1;
            got          = core_gnt_o;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            flush_i      = 1'b0;
            if (mem_req_o) begin
                if (f_nreq == 0) f_maddr = mem_addr_o;
                else if (mem_addr_o !== f_maddr || core_gnt_o) f_stable = 0;
                f_nreq++;
            end
            if (phase == 0 && mem_req_o) begin
                phase = 1;
                cnt   = 0;
            end
            if (phase == 1) begin
                if (cnt == gdly) begin
                    mem_gnt_i = 1'b1;
                    phase     = 2;
                    cnt       = 0;
                end else begin
                    cnt++;
                end
            end else if (phase == 2) begin
                if (flush_rv && !flushed) begin
                    flush_i = 1'b1;
                    flushed = 1;
                    poison  = 1;
                end
                if (cnt == rdly) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = poison ? ~line_data(addr) : line_data(addr);
                    poison       = 0;
                    phase        = 0;
                end else begin
                    cnt++;
                end
            end
            @(posedge clk);
            #1;
            f_ncyc++;
        end
        core_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        flush_i      = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL fetch_timeout: addr %h not granted after %0d cycles", addr, f_ncyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 0; core_req_i = 0; core_addr_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
        exp_hit = '0; exp_miss = '0;
        idle_cycle();
        idle_cycle();
        n_tests += 4;
        if (core_gnt_o !== 1'b0 || core_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_core_ctl: gnt=%b rvalid=%b expected 0 0", core_gnt_o, core_rvalid_o);
        end
        if (core_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected 0", core_rdata_o);
        end
        if (mem_req_o !== 1'b0 || mem_addr_o !== '0) begin
            n_fail++; $display("FAIL reset_mem: req=%b addr=%h expected 0 0", mem_req_o, mem_addr_o);
        end
        if (hit_cnt_o !== '0 || miss_cnt_o !== '0) begin
            n_fail++; $display("FAIL reset_cnt: hit=%0d miss=%0d expected 0 0", hit_cnt_o, miss_cnt_o);
        end
        rst_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_first_miss();
        fetch(22'h100, 0, 0, 0);
        exp_miss = sat(exp_miss); exp_hit = sat(exp_hit);
        idle_cycle();
        n_tests += 4;
        if (f_nreq != 1 || f_maddr !== 22'h100) begin
            n_fail++; $display("FAIL miss_req: reqs=%0d addr=%h expected 1 100", f_nreq, f_maddr);
        end
        if (f_ncyc != 3) begin
            n_fail++; $display("FAIL miss_latency: got %0d cycles expected 3", f_ncyc);
        end
        if (miss_cnt_o !== exp_miss || hit_cnt_o !== exp_hit) begin
            n_fail++; $display("FAIL miss_cnts: hit=%0d miss=%0d expected %0d %0d", hit_cnt_o, miss_cnt_o, exp_hit, exp_miss);
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL miss_rvalid: %0d grants without rvalid expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int start;
        int reqs;
        start = cyc;
        reqs  = 0;
        foreach (exp_q[i]) reqs = reqs;
        for (int i = 0; i < 4; i++) begin
            // The last address carries nonzero byte-offset bits, which must be ignored.
            fetch((i == 3) ? 22'h10F : 22'h104 + 22'(4 * i), 0, 0, 0);
            reqs += f_nreq;
            exp_hit = sat(exp_hit);
        end
        n_tests += 2;
        if (cyc - start != 4) begin
            n_fail++; $display("FAIL b2b_rate: 4 grants took %0d cycles expected 4", cyc - start);
        end
        if (reqs != 0) begin
            n_fail++; $display("FAIL b2b_memreq: got %0d refill cycles expected 0", reqs);
        end
        idle_cycle();
        n_tests++;
        if (hit_cnt_o !== exp_hit || exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_hits: hit=%0d pending=%0d expected %0d 0", hit_cnt_o, exp_q.size(), exp_hit);
        end
    endtask

    task automatic test_miss_wait_gnt();
        fetch(22'h110, 3, 0, 0);
        exp_miss = sat(exp_miss); exp_hit = sat(exp_hit);
        idle_cycle();
        n_tests += 3;
        if (f_nreq != 4 || f_maddr !== 22'h110) begin
            n_fail++; $display("FAIL wait_gnt_req: reqs=%0d addr=%h expected 4 110", f_nreq, f_maddr);
        end
        if (!f_stable) begin
            n_fail++; $display("FAIL wait_gnt_stable: addr or gnt changed, got 0 expected 1");
        end
        if (f_ncyc != 6 || miss_cnt_o !== exp_miss) begin
            n_fail++; $display("FAIL wait_gnt_latency: cycles=%0d miss=%0d expected 6 %0d", f_ncyc, miss_cnt_o, exp_miss);
        end
    endtask

    task automatic test_flush();
        fetch(22'h200, 0, 1, 1);
        exp_miss = sat(sat(exp_miss)); exp_hit = sat(exp_hit);
        idle_cycle();
        n_tests += 2;
        if (f_nreq != 2 || f_ncyc != 7) begin
            n_fail++; $display("FAIL flush_refetch: reqs=%0d cycles=%0d expected 2 7", f_nreq, f_ncyc);
        end
        if (miss_cnt_o !== exp_miss || hit_cnt_o !== exp_hit) begin
            n_fail++; $display("FAIL flush_cnts: hit=%0d miss=%0d expected %0d %0d", hit_cnt_o, miss_cnt_o, exp_hit, exp_miss);
        end
        // Flush in IDLE turns an otherwise-hitting request into a miss.
        core_req_i = 1'b1; core_addr_i = 22'h204; flush_i = 1'b1;
        #1;
        n_tests++;
        if (core_gnt_o !== 1'b0 || mem_req_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_idle: gnt=%b mem_req=%b expected 0 1", core_gnt_o, mem_req_o);
        end
        core_req_i = 1'b0;
        idle_cycle();
        flush_i = 1'b0;
        fetch(22'h204, 0, 0, 0);
        exp_miss = sat(exp_miss); exp_hit = sat(exp_hit);
        idle_cycle();
        n_tests++;
        if (f_nreq != 1 || miss_cnt_o !== exp_miss) begin
            n_fail++; $display("FAIL flush_invalid: reqs=%0d miss=%0d expected 1 %0d", f_nreq, miss_cnt_o, exp_miss);
        end
    endtask

    task automatic test_saturate();
        int i;
        i = 0;
        while (exp_miss != 4'd14 && i < 20) begin
            fetch(22'h1000 + 22'(16 * i), 0, 0, 0);
            exp_miss = sat(exp_miss); exp_hit = sat(exp_hit);
            i++;
        end
        idle_cycle();
        n_tests++;
        if (miss_cnt_o !== 4'd14) begin
            n_fail++; $display("FAIL sat_pre: miss=%0d expected 14", miss_cnt_o);
        end
        fetch(22'h3000, 0, 0, 0);
        fetch(22'h3010, 0, 0, 0);
        exp_miss = sat(sat(exp_miss)); exp_hit = sat(sat(exp_hit));
        idle_cycle();
        n_tests += 2;
        if (miss_cnt_o !== 4'hF || exp_miss !== 4'hF) begin
            n_fail++; $display("FAIL sat_miss: miss=%0d expected 15", miss_cnt_o);
        end
        if (hit_cnt_o !== exp_hit) begin
            n_fail++; $display("FAIL sat_hit: hit=%0d expected %0d", hit_cnt_o, exp_hit);
        end
    endtask

    task automatic test_reset_mid_refill();
        core_req_i = 1'b1; core_addr_i = 22'h300;
        #1;
        n_tests++;
        if (mem_req_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_refill_start: mem_req=%b expected 1", mem_req_o);
        end
        mem_gnt_i = 1'b1;
        idle_cycle();
        core_req_i = 1'b0; mem_gnt_i = 1'b0;
        rst_n = 1'b0;
        exp_hit = '0; exp_miss = '0;
        idle_cycle();
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = line_data(22'h300);
        idle_cycle();
        mem_rvalid_i = 1'b0;
        n_tests += 3;
        if (core_gnt_o !== 1'b0 || core_rvalid_o !== 1'b0 || core_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_core: gnt=%b rvalid=%b rdata=%h expected 0 0 0", core_gnt_o, core_rvalid_o, core_rdata_o);
        end
        if (mem_req_o !== 1'b0 || mem_addr_o !== '0) begin
            n_fail++; $display("FAIL rst_mem: req=%b addr=%h expected 0 0", mem_req_o, mem_addr_o);
        end
        if (hit_cnt_o !== '0 || miss_cnt_o !== '0) begin
            n_fail++; $display("FAIL rst_cnt: hit=%0d miss=%0d expected 0 0", hit_cnt_o, miss_cnt_o);
        end
        fetch(22'h300, 0, 0, 0);
        exp_miss = sat(exp_miss); exp_hit = sat(exp_hit);
        idle_cycle();
        n_tests += 2;
        if (f_nreq != 1 || f_ncyc != 3) begin
            n_fail++; $display("FAIL rst_not_installed: reqs=%0d cycles=%0d expected 1 3", f_nreq, f_ncyc);
        end
        if (miss_cnt_o !== exp_miss || hit_cnt_o !== exp_hit || exp_q.size() != 0) begin
            n_fail++; $display("FAIL rst_after: hit=%0d miss=%0d pending=%0d expected %0d %0d 0",
                               hit_cnt_o, miss_cnt_o, exp_q.size(), exp_hit, exp_miss);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_first_miss();
        test_back_to_back();
        test_miss_wait_gnt();
        test_flush();
        test_saturate();
        test_reset_mid_refill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
